// File: rtl/egg_timer_pkg.sv
// ============================================================================
// Module  : egg_timer_pkg
// Purpose : State encoding and BCD limits shared by the countdown sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] value, input logic [3:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
// Module  : bcd_down_digit
// Purpose : One BCD down-counting digit with clamped load and borrow chaining.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_digit
  import egg_timer_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] r_digit;
  logic       w_step;

  // A digit steps only when the whole chain below it is rolling over.
  assign w_step     = dec & borrow_in;
  assign borrow_out = w_step & (r_digit == 4'd0);
  assign digit      = r_digit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= 4'd0;
    end else if (clear) begin
      r_digit <= 4'd0;
    end else if (load) begin
      r_digit <= bcd_clamp(load_val, MAX);
    end else if (w_step) begin
      r_digit <= (r_digit == 4'd0) ? MAX : r_digit - 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/countdown_sequencer.sv
// ============================================================================
// Module  : countdown_sequencer
// Purpose : mm:ss BCD egg-timer with run/pause/alarm control and buzzer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_sequencer
  import egg_timer_pkg::*;
#(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load_en,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       running,
  output logic       buzzer,
  output logic       done
);

  localparam logic [7:0] c_alarm_last = 8'(ALARM_SECS - 1);

  state_t     r_state;
  logic       r_buzzer;
  logic       r_done;
  logic [7:0] r_alarm_cnt;

  logic       w_zero;
  logic       w_one;
  logic       w_dec;
  logic       w_clear;
  logic       w_load;
  logic       w_borrow_so;
  logic       w_borrow_st;
  logic       w_borrow_mo;
  logic       w_unused_borrow_mt;

  assign w_zero  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
  assign w_one   = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);
  // Cancel outranks the tick, and the count never steps below 00:00.
  assign w_dec   = (r_state == ST_RUN) & tick_1hz & ~cancel & ~w_zero;
  assign w_clear = cancel & (r_state != ST_IDLE);
  assign w_load  = load_en & (r_state == ST_IDLE);

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .reset(reset), .clear(w_clear), .load(w_load), .load_val(load_sec_ones),
    .dec(w_dec), .borrow_in(1'b1), .digit(sec_ones), .borrow_out(w_borrow_so)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .reset(reset), .clear(w_clear), .load(w_load), .load_val(load_sec_tens),
    .dec(w_dec), .borrow_in(w_borrow_so), .digit(sec_tens), .borrow_out(w_borrow_st)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(clk), .reset(reset), .clear(w_clear), .load(w_load), .load_val(load_min_ones),
    .dec(w_dec), .borrow_in(w_borrow_st), .digit(min_ones), .borrow_out(w_borrow_mo)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk(clk), .reset(reset), .clear(w_clear), .load(w_load), .load_val(load_min_tens),
    .dec(w_dec), .borrow_in(w_borrow_mo), .digit(min_tens), .borrow_out(w_unused_borrow_mt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_buzzer    <= 1'b0;
      r_done      <= 1'b0;
      r_alarm_cnt <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!load_en && start && !w_zero) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else if (tick_1hz && w_one) begin
            r_state     <= ST_ALARM;
            r_done      <= 1'b1;
            r_buzzer    <= 1'b1;
            r_alarm_cnt <= 8'd0;
          end else if (pause) begin
            r_state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else if (start) begin
            r_state <= ST_RUN;
          end
        end
        ST_ALARM: begin
          if (cancel || start) begin
            r_state     <= ST_IDLE;
            r_buzzer    <= 1'b0;
            r_alarm_cnt <= 8'd0;
          end else if (tick_1hz) begin
            if (r_alarm_cnt == c_alarm_last) begin
              r_state     <= ST_IDLE;
              r_buzzer    <= 1'b0;
              r_alarm_cnt <= 8'd0;
            end else begin
              r_buzzer    <= ~r_buzzer;
              r_alarm_cnt <= r_alarm_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign state   = r_state;
  assign running = (r_state == ST_RUN);
  assign buzzer  = r_buzzer;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_countdown_sequencer.sv
// ============================================================================
// Module  : tb_countdown_sequencer
// Purpose : Directed and randomized checks of countdown_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_sequencer;

  localparam int ALARM_SECS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, load_en = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic [3:0] load_min_tens = 4'd0, load_min_ones = 4'd0, load_sec_tens = 4'd0, load_sec_ones = 4'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] state;
  logic       running, buzzer, done;

  countdown_sequencer #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .load_en(load_en),
    .load_min_tens(load_min_tens), .load_min_ones(load_min_ones),
    .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
    .start(start), .pause(pause), .cancel(cancel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .state(state), .running(running), .buzzer(buzzer), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the count is a plain number of seconds.
  int m_secs, m_state, m_acnt;
  bit m_buzz, m_done;

  logic [15:0] disp;
  logic [20:0] status;
  assign disp   = {min_tens, min_ones, sec_tens, sec_ones};
  assign status = {state, running, buzzer, done, disp};

  function automatic int clampv(input logic [3:0] v, input int max);
    return (int'(v) > max) ? max : int'(v);
  endfunction

  function automatic logic [15:0] exp_disp();
    int m = m_secs / 60;
    int s = m_secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [20:0] exp_status();
    return {2'(m_state), (m_state == 1), m_buzz, m_done, exp_disp()};
  endfunction

  function automatic void model_reset();
    m_secs = 0; m_state = 0; m_acnt = 0; m_buzz = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    m_done = 0;
    case (m_state)
      0: begin
        if (load_en)
          m_secs = clampv(load_min_tens, 9) * 600 + clampv(load_min_ones, 9) * 60
                 + clampv(load_sec_tens, 5) * 10 + clampv(load_sec_ones, 9);
        else if (start && m_secs != 0)
          m_state = 1;
      end
      1: begin
        if (cancel) begin
          m_state = 0; m_secs = 0;
        end else begin
          if (tick_1hz) m_secs = m_secs - 1;
          if (tick_1hz && m_secs == 0) begin
            m_done = 1; m_state = 3; m_buzz = 1; m_acnt = 0;
          end else if (pause) begin
            m_state = 2;
          end
        end
      end
      2: begin
        if (cancel) begin
          m_state = 0; m_secs = 0;
        end else if (start) begin
          m_state = 1;
        end
      end
      default: begin
        if (cancel || start) begin
          m_state = 0; m_buzz = 0; m_acnt = 0; m_secs = 0;
        end else if (tick_1hz) begin
          m_acnt = m_acnt + 1;
          if (m_acnt == ALARM_SECS) begin
            m_state = 0; m_buzz = 0; m_acnt = 0;
          end else begin
            m_buzz = !m_buzz;
          end
        end
      end
    endcase
  endfunction

  task automatic set_load(input int mt, input int mo, input int st, input int so);
    load_min_tens = 4'(mt); load_min_ones = 4'(mo);
    load_sec_tens = 4'(st); load_sec_ones = 4'(so);
  endtask

  // Apply one clock of inputs; returns 1 ns after the edge.
  task automatic drive(input bit ld, input bit st, input bit pa, input bit ca, input bit tk);
    load_en = ld; start = st; pause = pa; cancel = ca; tick_1hz = tk;
    @(posedge clk);
    model_step();
    #1;
    load_en = 0; start = 0; pause = 0; cancel = 0; tick_1hz = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    total++;
    if (status !== 21'd0) begin
      bad++; $display("FAIL reset_state: got %h expected %h", status, 21'd0);
    end
    @(posedge clk); #1;
    reset = 0;
    drive(0, 1, 0, 0, 1);
    total++;
    if (status !== exp_status() || state !== 2'd0) begin
      bad++; $display("FAIL reset_start_zero: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_load_clamp();
    set_load(0, 0, 7, 12);
    drive(1, 0, 0, 0, 0);
    total++;
    if (disp !== 16'h0059 || status !== exp_status()) begin
      bad++; $display("FAIL load_clamp_sec: got %h expected %h", disp, 16'h0059);
    end
    set_load(15, 14, 9, 9);
    drive(1, 1, 0, 0, 0);
    total++;
    if (disp !== 16'h9959 || state !== 2'd0 || status !== exp_status()) begin
      bad++; $display("FAIL load_with_start: got %h expected %h", status, exp_status());
    end
    set_load(0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    total++;
    if (state !== 2'd0 || disp !== 16'h0000) begin
      bad++; $display("FAIL start_at_zero: got state %0d disp %h expected state 0 disp 0000", state, disp);
    end
  endtask

  task automatic test_full_minute();
    set_load(0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    total++;
    if (state !== 2'd1 || running !== 1'b1) begin
      bad++; $display("FAIL minute_start: got state %0d running %b expected 1 1", state, running);
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (disp !== 16'h0059 || status !== exp_status()) begin
      bad++; $display("FAIL minute_first_tick: got %h expected %h", disp, 16'h0059);
    end
    for (int i = 0; i < 58; i++) drive(0, 0, 0, 0, 1);
    total++;
    if (disp !== 16'h0001 || state !== 2'd1 || done !== 1'b0) begin
      bad++; $display("FAIL minute_at_one: got %h expected %h", status, exp_status());
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (disp !== 16'h0000 || done !== 1'b1 || state !== 2'd3 || buzzer !== 1'b1) begin
      bad++; $display("FAIL minute_expire: got %h expected %h", status, exp_status());
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (done !== 1'b0 || state !== 2'd3 || status !== exp_status()) begin
      bad++; $display("FAIL done_one_clk: got %h expected %h", status, exp_status());
    end
    drive(0, 1, 0, 0, 0);
    total++;
    if (state !== 2'd0 || buzzer !== 1'b0 || status !== exp_status()) begin
      bad++; $display("FAIL alarm_ack: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_alarm_timeout();
    bit exp_b [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    set_load(0, 0, 0, 3);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      total++;
      if (buzzer !== exp_b[i] || state !== 2'd3) begin
        bad++; $display("FAIL alarm_buzz_%0d: got buzzer %b state %0d expected %b 3", i, buzzer, state, exp_b[i]);
      end
      drive(0, 0, 0, 0, 1);
    end
    total++;
    if (state !== 2'd0 || buzzer !== 1'b0 || status !== exp_status()) begin
      bad++; $display("FAIL alarm_timeout: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_pause();
    drive(0, 0, 1, 0, 0);
    set_load(1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 1);
    total++;
    if (disp !== 16'h0959 || state !== 2'd2) begin
      bad++; $display("FAIL tick_and_pause: got %h expected %h", status, exp_status());
    end
    set_load(3, 3, 3, 3);
    for (int i = 0; i < 5; i++) drive(i == 2, 0, 0, 0, 1);
    total++;
    if (disp !== 16'h0959 || state !== 2'd2 || status !== exp_status()) begin
      bad++; $display("FAIL pause_hold: got %h expected %h", status, exp_status());
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    total++;
    if (disp !== 16'h0958 || state !== 2'd1) begin
      bad++; $display("FAIL resume: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_cancel();
    drive(0, 0, 0, 1, 0);
    set_load(0, 5, 3, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    total++;
    if (disp !== 16'h0530 || state !== 2'd1) begin
      bad++; $display("FAIL cancel_setup: got %h expected %h", status, exp_status());
    end
    drive(0, 1, 1, 1, 1);
    total++;
    if (disp !== 16'h0000 || state !== 2'd0 || status !== exp_status()) begin
      bad++; $display("FAIL cancel_priority: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_async_reset();
    set_load(0, 0, 2, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    reset = 1;
    #1;
    model_reset();
    total++;
    if (status !== 21'd0) begin
      bad++; $display("FAIL async_reset: got %h expected %h", status, 21'd0);
    end
    #1;
    reset = 0;
    set_load(0, 2, 1, 5);
    drive(1, 0, 0, 0, 0);
    total++;
    if (disp !== 16'h0215 || state !== 2'd0) begin
      bad++; $display("FAIL load_after_reset: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_load(0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 0);
      total++;
      if (status !== exp_status()) begin
        bad++; $display("FAIL random_cycle_%0d: got %h expected %h", i, status, exp_status());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_clamp();
    test_full_minute();
    test_alarm_timeout();
    test_pause();
    test_cancel();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
